// File: rtl/inst_mem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words for the
// instruction memory and holds the core in reset until the load ends. Optional checksum: INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter  int NUM_INST = 128,
    localparam int AW       = $clog2(NUM_INST)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [AW:0]   num_words,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          chk_err
);

    localparam logic [AW:0] MAX_N = (AW+1)'(NUM_INST);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
`ifdef INST_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHECK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t      state, state_nxt;
    logic        load_go;
    logic [AW:0] n;
    logic [AW:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_lo;
    logic        xfer;
    logic        last_word;

    assign xfer      = (state == S_LOAD) && in_valid;
    assign last_word = ((word_idx + ONE) == n);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        cpu_hold  = 1'b1;
        load_go   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (load_start) begin
                    load_go   = 1'b1;
                    state_nxt = (num_words == '0) ? S_END : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                state_nxt = last_word ? S_END : S_LOAD;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (load_start) begin
                    load_go   = 1'b1;
                    state_nxt = (num_words == '0) ? S_END : S_LOAD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The fourth byte goes straight into mem_wdata, so the write port holds the
    // last written word until the next one is complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            n         <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_lo   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (load_go) begin
                n        <= (num_words > MAX_N) ? MAX_N : num_words;
                word_idx <= '0;
                byte_idx <= '0;
            end
            if (xfer) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_lo[7:0]   <= in_data;
                    2'd1: word_lo[15:8]  <= in_data;
                    2'd2: word_lo[23:16] <= in_data;
                    default: begin
                        mem_addr  <= word_idx[AW-1:0];
                        mem_wdata <= {in_data, word_lo};
                    end
                endcase
            end
            if (state == S_WRITE) word_idx <= word_idx + ONE;
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
    logic       chk_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_acc   <= '0;
            chk_err_q <= 1'b0;
        end else if (load_go) begin
            xor_acc   <= '0;
            chk_err_q <= 1'b0;
        end else if (xfer) begin
            xor_acc <= xor_acc ^ in_data;
        end else if (state == S_CHECK && in_valid) begin
            chk_err_q <= (in_data != xor_acc);
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: stimulus pushes expected writes, a
// negedge monitor pops and compares them and checks write latency.
module tb_inst_mem_loader;

    localparam int AW = 7;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   num_words;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          chk_err;

    wr_t  sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    bit   gap    = 1'b0;
    logic [7:0] run_xor;

    inst_mem_loader #(.NUM_INST(128)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .num_words(num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: write contents from the scoreboard, write exactly one cycle after the 4th byte.
    initial begin : monitor
        int  byte_cnt = 0;
        bit  exp_we   = 1'b0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                byte_cnt = 0;
                exp_we   = 1'b0;
            end else begin
                if (exp_we || mem_we) check("we_latency", mem_we, exp_we);
                if (mem_we) begin
                    wr_cnt++;
                    check("ready_in_write", in_ready, 0);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                    end else begin
                        check("unexpected_write", mem_we, 0);
                    end
                end
                exp_we = 1'b0;
                if (load_start) byte_cnt = 0;
                if (in_valid && in_ready) begin
                    byte_cnt = (byte_cnt + 1) % 4;
                    if (byte_cnt == 0) exp_we = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start(input int nw);
        load_start = 1'b1;
        num_words  = nw[AW:0];
        run_xor    = 8'h00;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) check("xfer_timeout", in_ready, 1);
        run_xor = run_xor ^ b;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // With the checksum option the load ends with one extra byte.
    task automatic finish_load();
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
    endtask

    task automatic wait_done(input logic exp_chk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done", done, 1);
        check("cpu_hold_done", cpu_hold, 0);
        check("chk_err", chk_err, exp_chk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_chk_err"}, chk_err, 0);
    endtask

    logic [7:0] prog [12] = '{8'h93, 8'h02, 8'hB0, 8'h07,
                              8'h13, 8'h03, 8'h80, 8'h1C,
                              8'hB3, 8'h83, 8'h62, 8'h00};

    initial begin : stim
        int wr_before;
        reset      = 1'b1;
        load_start = 1'b0;
        num_words  = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        run_xor    = '0;
        do_reset();
        check_reset_outputs("rst");

        // 1) three words, back-to-back bytes
        for (int pass = 0; pass < 2; pass++) begin
            gap = (pass == 1);
            start(3);
            check("hold_loading", cpu_hold, 1);
            sb.push_back('{addr: 7'd0, data: 32'h07B00293});
            sb.push_back('{addr: 7'd1, data: 32'h1C800313});
            sb.push_back('{addr: 7'd2, data: 32'h006283B3});
            for (int i = 0; i < 12; i++) send_byte(prog[i]);
            finish_load();
            wait_done(1'b0);
            check("sb_empty_t1", sb.size(), 0);
            // 2) second pass repeats with in_valid toggling
        end
        gap = 1'b0;

        // 3) clamp: 200 requested, 128 written
        wr_before = wr_cnt;
        start(200);
        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            w = {i[7:0], 8'hC3, i[7:0] ^ 8'h5A, 8'h11};
            sb.push_back('{addr: i[AW-1:0], data: w});
            send_word(w);
        end
        finish_load();
        wait_done(1'b0);
        check("clamp_writes", wr_cnt - wr_before, 128);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("extra_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;

        // 4) reset after 6 bytes, then a one-word load
        start(2);
        sb.push_back('{addr: 7'd0, data: 32'h44332211});
        send_word(32'h44332211);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_reset_outputs("midrst");
        start(1);
        sb.push_back('{addr: 7'd0, data: 32'hDEADBEEF});
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        finish_load();
        wait_done(1'b0);
        check("sb_empty_t4", sb.size(), 0);

`ifdef INST_LOADER_CHECKSUM_EN
        // 5) checksum good (FF) then bad (00)
        start(1);
        sb.push_back('{addr: 7'd0, data: 32'h88442211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h44); send_byte(8'h88);
        send_byte(8'hFF);
        wait_done(1'b0);
        start(1);
        sb.push_back('{addr: 7'd0, data: 32'h88442211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h44); send_byte(8'h88);
        send_byte(8'h00);
        wait_done(1'b1);
        start(1);
        check("chk_err_clear", chk_err, 0);
        sb.push_back('{addr: 7'd0, data: 32'h01020304});
        send_word(32'h01020304);
        finish_load();
        wait_done(1'b0);
`endif

        // 6) zero words, then restart from DONE
        wr_before = wr_cnt;
        start(0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h00);
        wait_done(1'b0);
`else
        check("zero_done", done, 1);
        check("zero_hold", cpu_hold, 0);
`endif
        check("zero_writes", wr_cnt - wr_before, 0);
        start(1);
        check("restart_done", done, 0);
        check("restart_hold", cpu_hold, 1);
        sb.push_back('{addr: 7'd0, data: 32'h0BADF00D});
        send_word(32'h0BADF00D);
        finish_load();
        wait_done(1'b0);

        repeat (2) @(posedge clk);
        check("sb_empty_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
